game_timer: RTL

Parametrised game-clock block: a prescaler divides the system clock into one-cycle `tick` pulses, and a seconds counter counts down from, or up to, a loaded value. It raises `expired` and a one-cycle `done` pulse at the terminal value. It replaces the fixed 100 MHz one-second enable in the fishing-game datapath and drives the round timer and the seven-segment time display. Unlike the earlier enable, `tick` never stays asserted while paused.

---
 rtl/game_timer_if.sv | 25 ++
 rtl/game_timer.sv | 105 ++++++++++
 2 files changed

// File: rtl/game_timer_if.sv
// game_timer_if: control/status bundle for the game clock.
//   master: drives run, pause, load, load_val; observes tick, seconds, expired, done.
//   slave : the timer itself (opposite directions).
interface game_timer_if #(
    parameter int SEC_W = 8
);
    logic             run;
    logic             pause;
    logic             load;
    logic [SEC_W-1:0] load_val;
    logic             tick;
    logic [SEC_W-1:0] seconds;
    logic             expired;
    logic             done;

    modport master (
        output run, pause, load, load_val,
        input  tick, seconds, expired, done
    );

    modport slave (
        input  run, pause, load, load_val,
        output tick, seconds, expired, done
    );
endinterface

// File: rtl/game_timer.sv
// game_timer: prescaled seconds counter for the round timer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus.run    : level, 0 forces IDLE and clears the prescaler
//   bus.pause  : level, freezes prescaler and counter while running
//   bus.load   : strobe, captures load_val (start value down / limit up)
//   bus.tick   : one-cycle pulse per prescaler wrap
//   bus.seconds: current count
//   bus.expired: high while the terminal value is held
//   bus.done   : one-cycle pulse on reaching the terminal value
// Parameters: DIV cycles per tick (>= 2), SEC_W counter width,
// UP = 0 counts down to 0, UP = 1 counts up from 0 to the loaded limit.
module game_timer #(
    parameter int DIV   = 100_000_000,
    parameter int SEC_W = 8,
    parameter int UP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    game_timer_if.slave       bus
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    presc;
    logic [SEC_W-1:0] seconds_q;
    logic [SEC_W-1:0] limit;
    logic             tick_q;
    logic             done_q;
    logic [SEC_W-1:0] term;
    logic [SEC_W-1:0] sec_next;

    // Terminal value: 0 counting down, the loaded limit counting up.
    always_comb begin
        term     = (UP != 0) ? limit : '0;
        sec_next = (UP != 0) ? seconds_q + SEC_W'(1) : seconds_q - SEC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            presc     <= '0;
            seconds_q <= '0;
            limit     <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (!bus.run) begin
                state <= ST_IDLE;
                presc <= '0;
            end else if (bus.load) begin
                // A load on a wrap edge wins; that tick is dropped.
                presc <= '0;
                state <= ST_RUN;
                if (UP != 0) begin
                    seconds_q <= '0;
                    limit     <= bus.load_val;
                end else begin
                    seconds_q <= bus.load_val;
                end
            end else begin
                case (state)
                    ST_IDLE: state <= ST_RUN;
                    ST_RUN: begin
                        if (seconds_q == term) begin
                            // Already at terminal (e.g. loaded 0 counting down).
                            state  <= ST_EXPIRED;
                            done_q <= 1'b1;
                            presc  <= '0;
                        end else if (bus.pause) begin
                            // Pause on a would-be wrap edge suppresses that tick.
                            state <= ST_PAUSED;
                        end else if (presc == PRESC_MAX) begin
                            presc     <= '0;
                            tick_q    <= 1'b1;
                            seconds_q <= sec_next;
                            if (sec_next == term) begin
                                state  <= ST_EXPIRED;
                                done_q <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    ST_PAUSED: begin
                        if (!bus.pause) state <= ST_RUN;
                    end
                    default: presc <= '0;  // EXPIRED: hold everything
                endcase
            end
        end
    end

    assign bus.tick    = tick_q;
    assign bus.seconds = seconds_q;
    assign bus.done    = done_q;
    assign bus.expired = (state == ST_EXPIRED);
endmodule
